keypad_scan: RTL and testbench

Matrix scanner for the 4x4 front-panel keypad. Drives the row lines, samples the column lines, debounces whole scan frames, and presents the debounced key as the 16-bit one-hot code consumed by the keypad-to-digit encoder and display logic. Its output contract is:
- A level one-hot code held for as long as the key is held.
- 16'h0000 when no key is pressed.
- A single-cycle strobe on each new press.

---
 rtl/keypad_scan.sv | 115 +++++++++++
 tb/tb_keypad_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and one-hot key output
//   Optional feature macro: KEYSCAN_REPEAT_EN (auto-repeat strobe while a key is held)
//   clk       in   system clock
//   RSTn      in   synchronous reset, active-high
//   col       in   [3:0] column lines, active-low, asynchronous
//   row       out  [3:0] row drive, active-low, one bit low at a time
//   onehot    out  [15:0] debounced key, bit = row*4+col, 0 = no key
//   key_code  out  [3:0] binary index of the last non-zero onehot
//   key_valid out  one-cycle strobe per accepted press (and per repeat if enabled)
module keypad_scan #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5,
    parameter int REPEAT_FRAMES   = 125
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] onehot,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {R0, R1, R2, R3} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_sync1, r_sync2;
    logic [15:0]   r_frame, r_prev;
    logic [3:0]    r_stable;
`ifdef KEYSCAN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] r_rep;
`endif

    logic        w_slot_end, w_frame_end, w_accept;
    logic [15:0] w_full, w_cand;
    logic [4:0]  w_pop;
    logic [3:0]  w_code, w_stable_nx;

    assign w_slot_end  = r_cnt == CW'(SCAN_DIV - 1);
    assign w_frame_end = w_slot_end && r_state == R3;
    // The row-3 nibble is still being captured this cycle, so splice it in directly
    assign w_full      = {~r_sync2, r_frame[11:0]};

    always_comb begin
        w_pop  = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + 5'(w_full[i]);
            if (w_full[i]) w_code = 4'(i);
        end
    end

    // Multi-key frames collapse to "no key"
    assign w_cand      = (w_pop == 5'd1) ? w_full : 16'h0000;
    assign w_stable_nx = (w_cand != r_prev) ? 4'd1 :
                         (r_stable == 4'(DEBOUNCE_FRAMES)) ? r_stable : r_stable + 4'd1;
    assign w_accept    = w_stable_nx == 4'(DEBOUNCE_FRAMES) && w_cand != onehot;

    always_ff @(posedge clk) begin
        if (RSTn) begin
            r_state   <= R0;
            row       <= 4'b1110;
            r_cnt     <= '0;
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_frame   <= '0;
            r_prev    <= '0;
            r_stable  <= '0;
            onehot    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
`ifdef KEYSCAN_REPEAT_EN
            r_rep     <= '0;
`endif
        end else begin
            r_sync1   <= col;
            r_sync2   <= r_sync1;
            key_valid <= 1'b0;
            if (w_slot_end) begin
                r_cnt                        <= '0;
                r_frame[{r_state, 2'b00} +: 4] <= ~r_sync2;
                r_state                      <= state_t'(r_state + 2'd1);
                row                          <= {row[2:0], row[3]};
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_frame_end) begin
                r_prev   <= w_cand;
                r_stable <= w_stable_nx;
                if (w_accept) begin
                    onehot <= w_cand;
                    if (w_cand != 16'h0000) begin
                        key_code  <= w_code;
                        key_valid <= 1'b1;
                    end
                end
`ifdef KEYSCAN_REPEAT_EN
                if (w_accept) begin
                    r_rep <= '0;
                end else if (onehot != 16'h0000) begin
                    if (r_rep == RW'(REPEAT_FRAMES - 1)) begin
                        r_rep     <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        r_rep <= r_rep + 1'b1;
                    end
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed bench for keypad_scan against a frame-level key model
module tb_keypad_scan;
    localparam int SD = 8;
    localparam int DB = 3;
    localparam int RF = 4;
    localparam int FL = 4 * SD;

    logic        clk = 1'b0;
    logic        RSTn = 1'b1;
    logic [3:0]  col, row;
    logic [15:0] onehot;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;
    int v_cnt  = 0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(RF)) dut (
        .clk(clk), .RSTn(RSTn), .col(col), .row(row),
        .onehot(onehot), .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its column low while its row is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
    end

    // Frame-level model: keys only change at frame starts, so each frame equals keys
    int          m_n = 0;
    int          m_stab = 0;
    int          m_rep = 0;
    logic [15:0] m_prev = 0, m_oh = 0, m_cand;
    logic [3:0]  m_code = 0;
    logic        m_valid = 0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (RSTn) begin
            m_n = 0; m_stab = 0; m_rep = 0; m_prev = 0; m_oh = 0; m_code = 0;
        end else begin
            if (m_n % FL == FL - 1) begin
                m_cand = ($countones(keys) == 1) ? keys : 16'h0000;
                m_stab = (m_cand == m_prev) ? ((m_stab + 1 > DB) ? DB : m_stab + 1) : 1;
                m_prev = m_cand;
                if (m_stab == DB && m_cand != m_oh) begin
                    m_oh  = m_cand;
                    m_rep = 0;
                    if (m_cand != 0) begin
                        m_code  = 4'($clog2(m_cand));
                        m_valid = 1'b1;
                    end
                end else if (m_oh != 0) begin
                    m_rep = m_rep + 1;
`ifdef KEYSCAN_REPEAT_EN
                    if (m_rep == RF) begin
                        m_rep   = 0;
                        m_valid = 1'b1;
                    end
`endif
                end
            end
            m_n = m_n + 1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] er;
        @(negedge clk);
        er = 4'hF ^ (4'h1 << ((m_n / SD) % 4));
        chk("row", {12'h0, row}, {12'h0, er});
        chk("onehot", onehot, m_oh);
        chk("key_code", {12'h0, key_code}, {12'h0, m_code});
        chk("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
        if (key_valid) v_cnt++;
    endtask

    task automatic align();
        while (m_n % FL != 1) tick();
    endtask

    task automatic frames(input int k);
        repeat (k) begin
            do tick(); while (m_n % FL != 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        logic [15:0] k;
        repeat (3) @(negedge clk);
        chk("rst_row", {12'h0, row}, 16'h000E);
        chk("rst_onehot", onehot, 16'h0000);
        chk("rst_code", {12'h0, key_code}, 16'h0000);
        chk("rst_valid", {15'h0, key_valid}, 16'h0000);
        RSTn = 1'b0;
        repeat (SD) tick();
        chk("row_step1", {12'h0, row}, 16'h000D);
        repeat (SD) tick();
        chk("row_step2", {12'h0, row}, 16'h000B);
        repeat (SD) tick();
        chk("row_step3", {12'h0, row}, 16'h0007);
        repeat (SD) tick();
        chk("row_wrap", {12'h0, row}, 16'h000E);
        align();

        // Stable press (1,2) then release
        keys = 16'h0040; v0 = v_cnt;
        frames(2);
        chk("press_early", onehot, 16'h0000);
        frames(1);
        chk("press_onehot", onehot, 16'h0040);
        chk("press_code", {12'h0, key_code}, 16'h0006);
        chk("press_pulses", 16'(v_cnt - v0), 16'd1);
        keys = 16'h0000; v0 = v_cnt;
        frames(3);
        chk("release_onehot", onehot, 16'h0000);
        chk("release_code", {12'h0, key_code}, 16'h0006);
        chk("release_pulses", 16'(v_cnt - v0), 16'd0);

        // Bounce on (0,0)
        v0 = v_cnt;
        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
            frames(1);
            chk("bounce_hold0", onehot, 16'h0000);
        end
        keys = 16'h0001;
        frames(2);
        chk("bounce_early", onehot, 16'h0000);
        frames(1);
        chk("bounce_onehot", onehot, 16'h0001);
        chk("bounce_pulses", 16'(v_cnt - v0), 16'd1);
        keys = 16'h0000;
        frames(4);

        // Multi-key (0,0)+(3,3), then release (3,3)
        keys = 16'h8001; v0 = v_cnt;
        frames(5);
        chk("multi_onehot", onehot, 16'h0000);
        chk("multi_pulses", 16'(v_cnt - v0), 16'd0);
        keys = 16'h0001;
        frames(3);
        chk("multi_release", onehot, 16'h0001);

        // Direct change (2,1) -> (3,0)
        keys = 16'h0200; v0 = v_cnt;
        frames(3);
        chk("direct_a", onehot, 16'h0200);
        chk("direct_a_code", {12'h0, key_code}, 16'h0009);
        chk("direct_a_pulses", 16'(v_cnt - v0), 16'd1);
        keys = 16'h1000; v0 = v_cnt;
        frames(3);
        chk("direct_b", onehot, 16'h1000);
        chk("direct_b_code", {12'h0, key_code}, 16'h000C);
        chk("direct_b_pulses", 16'(v_cnt - v0), 16'd1);

        // Reset in the middle of debouncing a new press (0,3)
        keys = 16'h0008;
        frames(2);
        chk("pre_reset", onehot, 16'h1000);
        RSTn = 1'b1;
        repeat (3) tick();
        chk("reset_onehot", onehot, 16'h0000);
        chk("reset_code", {12'h0, key_code}, 16'h0000);
        RSTn = 1'b0;
        align();
        frames(2);
        chk("post_reset_early", onehot, 16'h0000);
        frames(1);
        chk("post_reset_onehot", onehot, 16'h0008);

        // Long hold on (1,1)
        keys = 16'h0020; v0 = v_cnt;
        frames(14);
        chk("hold_onehot", onehot, 16'h0020);
`ifdef KEYSCAN_REPEAT_EN
        chk("hold_pulses", 16'(v_cnt - v0), 16'd3);
`else
        chk("hold_pulses", 16'(v_cnt - v0), 16'd1);
`endif

        // Randomized frame-level stimulus
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: k = keys;
                5, 6:          k = 16'h1 << $urandom_range(0, 15);
                7, 8:          k = 16'h0000;
                default:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            keys = k;
            frames(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
